// File: rtl/hmc_rf_pkg.sv
// Shared types for the HMC register bank: access FSM states, access kinds
// and the width of the latency down-counter.
package hmc_rf_pkg;

    // Wide enough for LATENCY up to 15
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } rf_state_t;

    // ACC_BAD covers out-of-range addresses and read+write collisions
    typedef enum logic [1:0] {
        ACC_NONE  = 2'd0,
        ACC_READ  = 2'd1,
        ACC_WRITE = 2'd2,
        ACC_BAD   = 2'd3
    } rf_access_t;

endpackage

// File: rtl/hmc_rf_reg_cell.sv
// One register of the bank: plain RW, write-1-to-clear, or read-only
// (value comes live from hardware, nothing stored).
module hmc_rf_reg_cell #(
    parameter int DATA_W = 64,
    parameter bit IS_RO  = 1'b0,
    parameter bit IS_W1C = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [DATA_W-1:0] i_hw_status,
    input  logic [DATA_W-1:0] i_hw_set,
    output logic [DATA_W-1:0] o_rd_value,
    output logic [DATA_W-1:0] o_cfg
);

    logic [DATA_W-1:0] r_value;
    logic [DATA_W-1:0] w_next;
    logic [DATA_W-1:0] w_clr;

    // Next value; W1C ORs hardware sets in after the clear so a same-cycle set wins
    always_comb begin
        w_clr = i_wr_en ? i_wr_data : '0;
        if (IS_RO)
            w_next = '0;
        else if (IS_W1C)
            w_next = (r_value & ~w_clr) | i_hw_set;
        else
            w_next = i_wr_en ? i_wr_data : r_value;
    end

    // Storage
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_value <= '0;
        else
            r_value <= w_next;
    end

    assign o_rd_value = IS_RO ? i_hw_status : r_value;
    assign o_cfg      = r_value;

endmodule

// File: rtl/hmc_rf_regbank.sv
// Register bank with a fixed-latency access FSM (IDLE -> WAIT -> DONE).
// One access in flight at a time; requests arriving while busy are dropped.
module hmc_rf_regbank
    import hmc_rf_pkg::*;
#(
    parameter int                  DATA_W   = 64,
    parameter int                  ADDR_W   = 4,
    parameter int                  NUM_REGS = 12,
    parameter int                  LATENCY  = 2,
    parameter logic [NUM_REGS-1:0] RO_MASK  = '0,
    parameter logic [NUM_REGS-1:0] W1C_MASK = '0
) (
    input  logic                       clk_hmc,
    input  logic                       res_hmc,
    input  logic [DATA_W-1:0]          rf_write_data,
    input  logic [ADDR_W-1:0]          rf_address,
    input  logic                       rf_read_en,
    input  logic                       rf_write_en,
    output logic [DATA_W-1:0]          rf_read_data,
    output logic                       rf_invalid_address,
    output logic                       rf_access_complete,
    output logic                       rf_busy,
    input  logic [NUM_REGS*DATA_W-1:0] hw_status_in,
    input  logic [NUM_REGS*DATA_W-1:0] hw_w1c_set,
    output logic [NUM_REGS*DATA_W-1:0] cfg_out
);

    // WAIT runs LATENCY-1 cycles: load LATENCY-2 and leave when the counter hits 0
    localparam logic [CNT_W-1:0]  LAT_LOAD = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);
    localparam logic [ADDR_W:0]   NREGS_W  = (ADDR_W+1)'(NUM_REGS);

    rf_state_t          r_state, w_state_nxt;
    rf_access_t         r_op, w_op_in;
    logic [CNT_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [DATA_W-1:0]  r_rd_hold;
    logic [DATA_W-1:0]  w_sel_val;
    logic [DATA_W-1:0]  w_done_data;
    logic               w_accept;
    logic               w_wr_hit;
    logic [DATA_W-1:0]  w_rd_val [NUM_REGS];
    logic [DATA_W-1:0]  w_cfg    [NUM_REGS];

    // FSM state register
    always_ff @(posedge clk_hmc or posedge res_hmc) begin
        if (res_hmc)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // FSM next state and accept strobe
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (rf_read_en || rf_write_en) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (LATENCY == 1) ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: if (r_cnt == '0) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Classify the incoming request
    always_comb begin
        if ((rf_read_en && rf_write_en) || ({1'b0, rf_address} >= NREGS_W))
            w_op_in = ACC_BAD;
        else if (rf_write_en)
            w_op_in = ACC_WRITE;
        else
            w_op_in = ACC_READ;
    end

    // Latch the request on accept and count down in WAIT
    always_ff @(posedge clk_hmc or posedge res_hmc) begin
        if (res_hmc) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_op    <= ACC_NONE;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_addr  <= rf_address;
            r_wdata <= rf_write_data;
            r_op    <= w_op_in;
            r_cnt   <= LAT_LOAD;
        end else if (r_state == ST_WAIT && r_cnt != '0) begin
            r_cnt   <= r_cnt - 1'b1;
        end
    end

    // Read mux over the cells; only meaningful for in-range addresses
    always_comb begin
        w_sel_val = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (r_addr == i[ADDR_W-1:0]) w_sel_val = w_rd_val[i];
    end

    assign w_done_data = (r_op == ACC_READ) ? w_sel_val : '0;
    assign w_wr_hit    = (r_state == ST_DONE) && (r_op == ACC_WRITE);

    // Hold the completion data until the next completion
    always_ff @(posedge clk_hmc or posedge res_hmc) begin
        if (res_hmc)
            r_rd_hold <= '0;
        else if (r_state == ST_DONE)
            r_rd_hold <= w_done_data;
    end

    assign rf_read_data       = (r_state == ST_DONE) ? w_done_data : r_rd_hold;
    assign rf_access_complete = (r_state == ST_DONE);
    assign rf_busy            = (r_state != ST_IDLE);
    assign rf_invalid_address = (r_op == ACC_BAD);

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        hmc_rf_reg_cell #(
            .DATA_W (DATA_W),
            .IS_RO  (RO_MASK[g]),
            .IS_W1C (W1C_MASK[g] & ~RO_MASK[g])
        ) u_cell (
            .i_clk       (clk_hmc),
            .i_rst       (res_hmc),
            .i_wr_en     (w_wr_hit && (r_addr == ADDR_W'(g))),
            .i_wr_data   (r_wdata),
            .i_hw_status (hw_status_in[g*DATA_W +: DATA_W]),
            .i_hw_set    (hw_w1c_set[g*DATA_W +: DATA_W]),
            .o_rd_value  (w_rd_val[g]),
            .o_cfg       (w_cfg[g])
        );
        assign cfg_out[g*DATA_W +: DATA_W] = w_cfg[g];
    end

endmodule

// File: tb/tb_hmc_rf_regbank.sv
// Randomized bench for hmc_rf_regbank against an array-based register model.
module tb_hmc_rf_regbank;

    localparam int DW  = 64;
    localparam int AW  = 4;
    localparam int NR  = 12;
    localparam int LAT = 2;
    localparam logic [NR-1:0] ROM  = 12'h081;  // regs 0 and 7 read-only
    localparam logic [NR-1:0] W1CM = 12'h221;  // regs 5, 9 W1C; reg 0 also set but RO wins

    logic              clk_hmc = 1'b0;
    logic              res_hmc;
    logic [DW-1:0]     rf_write_data;
    logic [AW-1:0]     rf_address;
    logic              rf_read_en, rf_write_en;
    logic [DW-1:0]     rf_read_data;
    logic              rf_invalid_address, rf_access_complete, rf_busy;
    logic [NR*DW-1:0]  hw_status_in, hw_w1c_set, cfg_out;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0]     mreg [NR];
    logic [DW-1:0]     exp_hold;

    hmc_rf_regbank #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .LATENCY(LAT),
        .RO_MASK(ROM), .W1C_MASK(W1CM)
    ) dut (
        .clk_hmc(clk_hmc), .res_hmc(res_hmc),
        .rf_write_data(rf_write_data), .rf_address(rf_address),
        .rf_read_en(rf_read_en), .rf_write_en(rf_write_en),
        .rf_read_data(rf_read_data), .rf_invalid_address(rf_invalid_address),
        .rf_access_complete(rf_access_complete), .rf_busy(rf_busy),
        .hw_status_in(hw_status_in), .hw_w1c_set(hw_w1c_set), .cfg_out(cfg_out)
    );

    always #5 clk_hmc = ~clk_hmc;

    task automatic chk(input string tag, input logic [NR*DW-1:0] got, input logic [NR*DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NR*DW-1:0] exp_cfg();
        logic [NR*DW-1:0] v;
        v = '0;
        for (int i = 0; i < NR; i++)
            if (!ROM[i]) v[i*DW +: DW] = mreg[i];
        return v;
    endfunction

    function automatic logic [DW-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [NR*DW-1:0] rnd_vec(input bit sparse);
        logic [NR*DW-1:0] v;
        for (int i = 0; i < NR; i++)
            v[i*DW +: DW] = sparse ? (rnd64() & rnd64() & rnd64()) : rnd64();
        return v;
    endfunction

    // One access; entered and left on a negedge with the DUT idle.
    task automatic do_acc(input bit rd, input bit wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, input logic [NR*DW-1:0] st,
                          input logic [NR*DW-1:0] setv, input bit poke);
        int k;
        bit bad;
        logic [DW-1:0] er;
        rf_read_en = rd; rf_write_en = wr; rf_address = addr; rf_write_data = wd;
        hw_status_in = st; hw_w1c_set = '0;
        @(posedge clk_hmc);
        @(negedge clk_hmc);
        rf_read_en = 1'b0; rf_write_en = 1'b0;
        chk("busy_after_accept", rf_busy, 1);
        if (poke) begin
            rf_write_en = 1'b1; rf_address = 4'd1; rf_write_data = rnd64();
        end
        k = 1;
        while (!rf_access_complete && k < 20) begin
            @(negedge clk_hmc);
            rf_write_en = 1'b0;
            k++;
        end
        rf_write_en = 1'b0;
        chk("latency", k, LAT);
        bad = (rd && wr) || (addr >= NR);
        if (bad || wr)       er = '0;
        else if (ROM[addr])  er = st[addr*DW +: DW];
        else                 er = mreg[addr];
        chk("invalid", rf_invalid_address, bad);
        chk("rdata_done", rf_read_data, er);
        chk("busy_done", rf_busy, 1);
        // model: write lands at the end of DONE, hardware sets win over clears
        hw_w1c_set = setv;
        if (!bad && wr && !ROM[addr]) begin
            if (W1CM[addr]) mreg[addr] = mreg[addr] & ~wd;
            else            mreg[addr] = wd;
        end
        for (int i = 0; i < NR; i++)
            if (W1CM[i] && !ROM[i]) mreg[i] = mreg[i] | setv[i*DW +: DW];
        exp_hold = er;
        @(negedge clk_hmc);
        hw_w1c_set = '0;
        chk("complete_drop", rf_access_complete, 0);
        chk("busy_drop", rf_busy, 0);
        chk("rdata_hold", rf_read_data, exp_hold);
        chk("cfg", cfg_out, exp_cfg());
    endtask

    initial begin
        logic [NR*DW-1:0] st, sv;
        int pulses, r;
        res_hmc = 1'b1; rf_read_en = 1'b0; rf_write_en = 1'b0;
        rf_address = '0; rf_write_data = '0; hw_status_in = '0; hw_w1c_set = '0;
        for (int i = 0; i < NR; i++) mreg[i] = '0;
        exp_hold = '0;

        @(negedge clk_hmc);
        chk("rst_complete", rf_access_complete, 0);
        chk("rst_busy", rf_busy, 0);
        chk("rst_invalid", rf_invalid_address, 0);
        chk("rst_rdata", rf_read_data, 0);
        chk("rst_cfg", cfg_out, 0);
        res_hmc = 1'b0;

        // write then read back
        st = rnd_vec(0);
        do_acc(0, 1, 4'd3, 64'hDEAD_BEEF_0000_0001, st, '0, 0);
        do_acc(1, 0, 4'd3, '0, st, '0, 0);
        chk("rd3_const", rf_read_data, 64'hDEAD_BEEF_0000_0001);

        // out-of-range read
        do_acc(1, 0, 4'd13, '0, st, '0, 0);
        chk("bad_addr_inv", rf_invalid_address, 1);

        // W1C: load 0xFF, clear 0x0F while hardware sets bit 0
        sv = '0; sv[5*DW +: DW] = 64'hFF;
        do_acc(1, 0, 4'd5, '0, st, sv, 0);
        sv = '0; sv[5*DW +: DW] = 64'h01;
        do_acc(0, 1, 4'd5, 64'h0F, st, sv, 0);
        chk("w1c5_val", cfg_out[5*DW +: DW], 64'hF1);

        // RO write dropped, read returns live status
        st = '0; st[0 +: DW] = 64'hABCD;
        do_acc(0, 1, 4'd0, 64'h1234, st, '0, 0);
        do_acc(1, 0, 4'd0, '0, st, '0, 0);
        chk("ro_rd", rf_read_data, 64'hABCD);

        // read+write collision
        do_acc(0, 1, 4'd2, 64'h5555, st, '0, 0);
        do_acc(1, 1, 4'd2, 64'hAAAA, st, '0, 0);
        chk("rw_both_inv", rf_invalid_address, 1);
        chk("rw_both_reg2", cfg_out[2*DW +: DW], 64'h5555);

        // request while busy is ignored: exactly one completion
        do_acc(1, 0, 4'd3, '0, st, '0, 1);
        pulses = 0;
        repeat (4) begin
            @(negedge clk_hmc);
            if (rf_access_complete) pulses++;
        end
        chk("no_extra_complete", pulses, 0);
        chk("poke_no_write", cfg_out, exp_cfg());

        // random traffic
        repeat (150) begin
            r = $urandom_range(0, 9);
            do_acc(r == 0 || (r >= 1 && r <= 5), r == 0 || r >= 6,
                   AW'($urandom_range(0, 15)), rnd64(),
                   rnd_vec(0), rnd_vec(1), $urandom_range(0, 7) == 0);
        end

        // reset in WAIT: no completion, everything cleared
        rf_write_en = 1'b1; rf_address = 4'd4; rf_write_data = rnd64();
        @(posedge clk_hmc);
        @(negedge clk_hmc);
        rf_write_en = 1'b0;
        res_hmc = 1'b1;
        #1;
        chk("rstw_complete", rf_access_complete, 0);
        chk("rstw_busy", rf_busy, 0);
        chk("rstw_rdata", rf_read_data, 0);
        @(negedge clk_hmc);
        res_hmc = 1'b0;
        for (int i = 0; i < NR; i++) mreg[i] = '0;
        exp_hold = '0;
        pulses = 0;
        repeat (4) begin
            @(negedge clk_hmc);
            if (rf_access_complete) pulses++;
        end
        chk("rstw_no_pulse", pulses, 0);
        chk("rstw_cfg", cfg_out, exp_cfg());
        do_acc(1, 0, 4'd4, '0, rnd_vec(0), '0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hmc_rf_regbank.md
HMC_RF_REGBANK -- requirements
Module: hmc_rf_regbank

Interface
REQ-001 SHALL have parameter DATA_W, default 64: register and data-bus width.
REQ-002 SHALL have parameter ADDR_W, default 4: address width.
REQ-003 SHALL have parameter NUM_REGS, default 12: implemented registers, at most 2**ADDR_W.
REQ-004 SHALL have parameter LATENCY, default 2: cycles from accept to complete, legal range 1..15.
REQ-005 SHALL have parameter RO_MASK [NUM_REGS], default 0: bit i=1 makes register i read-only, hardware-sourced.
REQ-006 SHALL have parameter W1C_MASK [NUM_REGS], default 0: bit i=1 makes register i write-1-to-clear; RO_MASK takes precedence.
REQ-007 SHALL have port clk_hmc, input, 1: the single clock.
REQ-008 SHALL have port res_hmc, input, 1: reset, asynchronous and active-high.
REQ-009 SHALL have port rf_write_data, input, DATA_W: value to write.
REQ-010 SHALL have port rf_address, input, ADDR_W: target register.
REQ-011 SHALL have port rf_read_en, input, 1: read request.
REQ-012 SHALL have port rf_write_en, input, 1: write request.
REQ-013 SHALL have port rf_read_data, output, DATA_W: read result, valid with rf_access_complete.
REQ-014 SHALL have port rf_invalid_address, output, 1: failed access, valid with rf_access_complete.
REQ-015 SHALL have port rf_access_complete, output, 1: one-cycle completion pulse.
REQ-016 SHALL have port rf_busy, output, 1: an access is in flight.
REQ-017 SHALL have port hw_status_in, input, NUM_REGS*DATA_W: live value for each RO register.
REQ-018 SHALL have port hw_w1c_set, input, NUM_REGS*DATA_W: per-bit set pulses for W1C registers.
REQ-019 SHALL have port cfg_out, output, NUM_REGS*DATA_W: current contents of every RW and W1C register.

Function
REQ-020 SHALL implement FSM IDLE -> WAIT -> DONE -> IDLE.
- IDLE: accept when rf_read_en or rf_write_en is high; latch address, data and operation.
- WAIT: count LATENCY-1 cycles, skipped when LATENCY=1.
- DONE: pulse rf_access_complete for exactly one cycle.
REQ-021 SHALL assert rf_access_complete exactly LATENCY cycles after the accept edge.
REQ-022 SHALL hold rf_busy high from the cycle after accept up to and including the DONE cycle.
REQ-023 SHALL ignore requests while rf_busy is high; they are not queued.
REQ-024 SHALL accept a new request in the cycle immediately after DONE.
REQ-025 SHALL flag rf_invalid_address, perform no write and return zero read data when the address is >= NUM_REGS.
REQ-026 SHALL treat rf_read_en and rf_write_en high together as invalid, with the same behaviour as REQ-025.
REQ-027 SHALL, on a read, return the register value sampled in the DONE cycle; RO registers return hw_status_in.
REQ-028 SHALL, on a write to an RW register, update it in the DONE cycle.
REQ-029 SHALL, on a write to a W1C register, clear the bits written as 1.
REQ-030 SHALL give a same-cycle hw_w1c_set priority over a W1C clear of the same bit.
REQ-031 SHALL drop writes to RO registers silently: complete asserted, invalid low.
REQ-032 SHALL OR hw_w1c_set into W1C registers every cycle, independent of the FSM.
REQ-033 SHALL hold rf_read_data until the next completion; a write completion drives it to zero.

Reset
REQ-034 SHALL, on res_hmc, immediately clear all registers, rf_read_data, rf_invalid_address, rf_access_complete and rf_busy to 0 and force the FSM to IDLE.
REQ-035 SHALL abort an in-flight access on reset mid-operation with no completion pulse and no register update.

Structure
REQ-036 SHALL place FSM state enum, latency-counter width and access-type enum in shared package hmc_rf_pkg.
REQ-037 SHALL implement per-register storage (RW/RO/W1C behaviour) in sub-module hmc_rf_reg_cell, instantiated NUM_REGS times.

Verification
REQ-038 Write 0xDEAD_BEEF_0000_0001 to addr 3, then read addr 3 -> complete 2 cycles after each accept; read data 0xDEAD_BEEF_0000_0001; invalid 0.
REQ-039 Read addr 13 (NUM_REGS=12) -> complete after 2 cycles; invalid 1; read data 0.
REQ-040 W1C reg 5 holds 0xFF; write 0x0F with hw_w1c_set=0x01 in the DONE cycle -> register becomes 0xF1.
REQ-041 Write 0x1234 to RO reg 0 while hw_status_in[0]=0xABCD, then read reg 0 -> invalid 0; read 0xABCD.
REQ-042 Second request 1 cycle after accept -> ignored, one complete pulse only; reset asserted in WAIT -> no complete pulse, target register unchanged.
REQ-043 Read and write enables high together at addr 2 -> invalid 1; reg 2 unchanged.
